sigmoid_table_loader: RTL and testbench

Upstream feeder for the 32-entry sigmoid lookup register bank in the digit recognizer activation path. It accepts packed table bytes over a valid/ready stream and unpacks each byte into two 4-bit entries. It drives the bank's shared write_en/address/data bus, one entry per cycle, and reports when the full table is resident.

---
 rtl/sigmoid_table_loader_pkg.sv | 17 +
 rtl/sigmoid_table_loader_if.sv | 24 ++
 rtl/sigmoid_loader_addr_counter.sv | 30 +++
 rtl/sigmoid_table_loader.sv | 150 +++++++++++++++
 tb/tb_sigmoid_table_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_table_loader_pkg.sv
// Constants and FSM state type shared by the sigmoid table loader and the register bank it feeds.
package sigmoid_pkg;

  localparam int NUM_SIGMOID_ENTRIES = 32;
  localparam int SIGMOID_ADDR_W      = 5;
  localparam int SIGMOID_DATA_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE_LO,
    WRITE_HI,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/sigmoid_table_loader_if.sv
// Packed-byte input stream plus the register-bank write bus driven by the loader.
interface sigmoid_table_loader_if
  import sigmoid_pkg::*;
#(
  parameter int ADDR_W = SIGMOID_ADDR_W,
  parameter int DATA_W = SIGMOID_DATA_W
);
  logic [2*DATA_W-1:0] byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic                write_en;
  logic [ADDR_W-1:0]   address_out;
  logic [DATA_W-1:0]   data_out;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, write_en, address_out, data_out
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, write_en, address_out, data_out
  );
endinterface

// File: rtl/sigmoid_loader_addr_counter.sv
// Even-address counter for the table loader: clear, step by two, flag the last byte pair.
module sigmoid_loader_addr_counter
  import sigmoid_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_SIGMOID_ENTRIES,
  parameter int ADDR_W      = SIGMOID_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              terminal
);
  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_reg <= '0;
    end else if (clear) begin
      addr_reg <= '0;
    end else if (inc) begin
      addr_reg <= addr_reg + ADDR_W'(2);
    end
  end

  assign addr     = addr_reg;
  // The pair being written occupies the last two entries.
  assign terminal = (addr_reg == ADDR_W'(NUM_ENTRIES - 2));
endmodule

// File: rtl/sigmoid_table_loader.sv
// Unpacks table bytes into two entries each and writes them to the sigmoid register bank.
// Define SIGMOID_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the table.
module sigmoid_table_loader
  import sigmoid_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_SIGMOID_ENTRIES,
  parameter int ADDR_W      = SIGMOID_ADDR_W,
  parameter int DATA_W      = SIGMOID_DATA_W
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  sigmoid_table_loader_if.master bus,
  output logic                   busy,
  output logic                   table_loaded,
  output logic                   load_error
);
  loader_state_t     state_reg;
  logic [DATA_W-1:0] hi_nibble_reg;
  logic              byte_ready_reg;
  logic              write_en_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [DATA_W-1:0] data_reg;
  logic              busy_reg;
  logic              loaded_reg;
  logic [ADDR_W-1:0] addr;
  logic              terminal;
  logic              handshake;
  logic              addr_inc;

  assign handshake = bus.byte_valid && byte_ready_reg;
  assign addr_inc  = (state_reg == WRITE_HI) && !start;

  sigmoid_loader_addr_counter #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (ADDR_W)
  ) u_addr_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (start),
    .inc      (addr_inc),
    .addr     (addr),
    .terminal (terminal)
  );

`ifdef SIGMOID_LOADER_CHECKSUM_EN
  logic [2*DATA_W-1:0] xor_reg;
  logic                error_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      xor_reg   <= '0;
      error_reg <= 1'b0;
    end else if (start) begin
      xor_reg   <= '0;
      error_reg <= 1'b0;
    end else if (state_reg == ACCEPT && handshake) begin
      xor_reg <= xor_reg ^ bus.byte_in;
    end else if (state_reg == CHECK && handshake && bus.byte_in != xor_reg) begin
      error_reg <= 1'b1;
    end
  end

  assign load_error = error_reg;
`else
  assign load_error = 1'b0;
`endif

  // Bus outputs default to zero each cycle so they only carry values during the two write states.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      hi_nibble_reg  <= '0;
      byte_ready_reg <= 1'b0;
      write_en_reg   <= 1'b0;
      address_reg    <= '0;
      data_reg       <= '0;
      busy_reg       <= 1'b0;
      loaded_reg     <= 1'b0;
    end else begin
      write_en_reg <= 1'b0;
      address_reg  <= '0;
      data_reg     <= '0;
      if (start) begin
        state_reg      <= ACCEPT;
        byte_ready_reg <= 1'b1;
        busy_reg       <= 1'b1;
        loaded_reg     <= 1'b0;
      end else begin
        case (state_reg)
          ACCEPT: begin
            if (handshake) begin
              state_reg      <= WRITE_LO;
              hi_nibble_reg  <= bus.byte_in[2*DATA_W-1:DATA_W];
              byte_ready_reg <= 1'b0;
              write_en_reg   <= 1'b1;
              address_reg    <= addr;
              data_reg       <= bus.byte_in[DATA_W-1:0];
            end
          end
          WRITE_LO: begin
            state_reg    <= WRITE_HI;
            write_en_reg <= 1'b1;
            address_reg  <= addr + ADDR_W'(1);
            data_reg     <= hi_nibble_reg;
          end
          WRITE_HI: begin
            if (terminal) begin
`ifdef SIGMOID_LOADER_CHECKSUM_EN
              state_reg      <= CHECK;
              byte_ready_reg <= 1'b1;
`else
              state_reg  <= DONE;
              busy_reg   <= 1'b0;
              loaded_reg <= 1'b1;
`endif
            end else begin
              state_reg      <= ACCEPT;
              byte_ready_reg <= 1'b1;
            end
          end
`ifdef SIGMOID_LOADER_CHECKSUM_EN
          CHECK: begin
            if (handshake) begin
              state_reg      <= DONE;
              byte_ready_reg <= 1'b0;
              busy_reg       <= 1'b0;
              loaded_reg     <= (bus.byte_in == xor_reg);
            end
          end
`endif
          IDLE, DONE: begin
          end
          default: begin
            state_reg      <= IDLE;
            byte_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.byte_ready  = byte_ready_reg;
  assign bus.write_en    = write_en_reg;
  assign bus.address_out = address_reg;
  assign bus.data_out    = data_reg;
  assign busy            = busy_reg;
  assign table_loaded    = loaded_reg;
endmodule

// File: tb/tb_sigmoid_table_loader.sv
// Directed bench for sigmoid_table_loader: reset, full loads, gapped stream, restart, mid-load reset.
module tb_sigmoid_table_loader;
  import sigmoid_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic start = 1'b0;
  logic busy, table_loaded, load_error;

  sigmoid_table_loader_if bus ();

  sigmoid_table_loader dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .table_loaded (table_loaded),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int tl_rise_cyc = 0;
  int w31_cyc = 0;
  logic [8:0] wq[$];
  logic we_prev = 1'b0;
  logic hs_prev = 1'b0;
  logic tl_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus monitor: records writes, checks the idle bus is zero and every write burst follows a handshake.
  always @(negedge clk) begin
    if (!n_rst) begin
      we_prev = 1'b0;
      hs_prev = 1'b0;
      tl_prev = 1'b0;
    end else begin
      if (bus.write_en === 1'b1) begin
        wq.push_back({bus.address_out, bus.data_out});
        if (bus.address_out == 5'd31) w31_cyc = cyc;
        if (!we_prev) chk("write_after_handshake", 32'(hs_prev), 1);
      end else begin
        chk("idle_bus_zero", 32'({bus.address_out, bus.data_out}), 0);
      end
      if (table_loaded === 1'b1 && !tl_prev) tl_rise_cyc = cyc;
      we_prev = bus.write_en;
      hs_prev = bus.byte_valid && bus.byte_ready && !start;
      tl_prev = table_loaded;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int j);
    logic [3:0] lo;
    lo = 4'((2 * j) % 16);
    return {lo + 4'd1, lo};
  endfunction

  task automatic pulse_start(input logic [7:0] offer, input logic offer_valid);
    start = 1'b1;
    bus.byte_in = offer;
    bus.byte_valid = offer_valid;
    tick();
    start = 1'b0;
    bus.byte_valid = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("accept_timeout", 32'(n < 64), 1);
    tick();
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic finish_load;
`ifdef SIGMOID_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    bus.byte_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_table(input string tag);
    int n;
    n = (wq.size() < 32) ? wq.size() : 32;
    chk({tag, "_count"}, 32'(wq.size()), 32);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 32'(wq[i][8:4]), 32'(i));
      chk({tag, "_data"}, 32'(wq[i][3:0]), 32'(i % 16));
    end
    $display("load %s: %0d writes, table_loaded=%0b", tag, wq.size(), table_loaded);
  endtask

  initial begin
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset asserted mid-cycle
    #3 n_rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'h10;
    #1;
    chk("rst_byte_ready", 32'(bus.byte_ready), 0);
    chk("rst_write_en", 32'(bus.write_en), 0);
    chk("rst_address", 32'(bus.address_out), 0);
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_loaded", 32'(table_loaded), 0);
    chk("rst_error", 32'(load_error), 0);
    tick();
    tick();
    n_rst = 1'b1;
    repeat (3) tick();
    chk("idle_byte_ready", 32'(bus.byte_ready), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_no_writes", 32'(wq.size()), 0);
    bus.byte_valid = 1'b0;
    $display("reset: outputs idle");

    // Continuous-valid full load
    wq.delete();
    pulse_start(8'h00, 1'b0);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_ready", 32'(bus.byte_ready), 1);
    for (int j = 0; j < 16; j++) send_byte(pat(j), 0);
    finish_load();
    check_table("continuous");
    chk("cont_loaded", 32'(table_loaded), 1);
    chk("cont_busy", 32'(busy), 0);
`ifndef SIGMOID_LOADER_CHECKSUM_EN
    chk("cont_load_cycles", 32'(tl_rise_cyc - start_cyc), 48);
    chk("cont_loaded_after_addr31", 32'(tl_rise_cyc - w31_cyc), 1);
`endif
    bus.byte_in = 8'h77;
    bus.byte_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("done_refuses_byte", 32'(bus.byte_ready), 0);
    end
    bus.byte_valid = 1'b0;
    chk("done_no_extra_writes", 32'(wq.size()), 32);

    // Gapped stream: valid drops for 5 cycles between bytes
    wq.delete();
    pulse_start(8'h00, 1'b0);
    chk("gap_loaded_cleared", 32'(table_loaded), 0);
    for (int j = 0; j < 16; j++) send_byte(pat(j), 5);
    finish_load();
    check_table("gapped");
    chk("gap_loaded", 32'(table_loaded), 1);

    // Restart after 5 bytes, mid-write, with a junk byte offered alongside start
    pulse_start(8'h00, 1'b0);
    chk("restart_loaded_cleared", 32'(table_loaded), 0);
    for (int j = 0; j < 5; j++) send_byte(pat(j), 0);
    pulse_start(8'hEE, 1'b1);
    chk("restart_write_aborted", 32'(bus.write_en), 0);
    chk("restart_loaded", 32'(table_loaded), 0);
    wq.delete();
    for (int j = 0; j < 15; j++) send_byte(pat(j), 0);
    bus.byte_valid = 1'b0;
    repeat (4) tick();
    chk("restart_15_not_loaded", 32'(table_loaded), 0);
    chk("restart_15_busy", 32'(busy), 1);
    send_byte(pat(15), 0);
    finish_load();
    check_table("restart");
    chk("restart_loaded_final", 32'(table_loaded), 1);

    // Reset pulse during WRITE_HI of byte 7
    wq.delete();
    pulse_start(8'h00, 1'b0);
    for (int j = 0; j < 8; j++) send_byte(pat(j), 0);
    bus.byte_valid = 1'b0;
    tick();
    chk("hi_write_en", 32'(bus.write_en), 1);
    chk("hi_address", 32'(bus.address_out), 15);
    #2 n_rst = 1'b0;
    #1;
    chk("async_write_en_drop", 32'(bus.write_en), 0);
    chk("async_address_zero", 32'(bus.address_out), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_loaded", 32'(table_loaded), 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.byte_ready), 0);
    chk("post_rst_loaded", 32'(table_loaded), 0);
    wq.delete();
    pulse_start(8'h00, 1'b0);
    for (int j = 0; j < 16; j++) send_byte(pat(j), 0);
    finish_load();
    check_table("after_reset");
    chk("after_reset_loaded", 32'(table_loaded), 1);

`ifdef SIGMOID_LOADER_CHECKSUM_EN
    // Checksum: sixteen 0xA5 bytes XOR to 0x00
    wq.delete();
    pulse_start(8'h00, 1'b0);
    for (int j = 0; j < 16; j++) send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    bus.byte_valid = 1'b0;
    repeat (3) tick();
    chk("csum_ok_loaded", 32'(table_loaded), 1);
    chk("csum_ok_error", 32'(load_error), 0);
    chk("csum_ok_count", 32'(wq.size()), 32);
    if (wq.size() >= 2) begin
      chk("csum_ok_data0", 32'(wq[0][3:0]), 32'h5);
      chk("csum_ok_data1", 32'(wq[1][3:0]), 32'hA);
    end
    $display("checksum 0x00: table_loaded=%0b load_error=%0b", table_loaded, load_error);
    pulse_start(8'h00, 1'b0);
    for (int j = 0; j < 16; j++) send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    bus.byte_valid = 1'b0;
    repeat (3) tick();
    chk("csum_bad_error", 32'(load_error), 1);
    chk("csum_bad_loaded", 32'(table_loaded), 0);
    chk("csum_bad_busy", 32'(busy), 0);
    $display("checksum 0x01: table_loaded=%0b load_error=%0b", table_loaded, load_error);
    pulse_start(8'h00, 1'b0);
    chk("csum_error_cleared", 32'(load_error), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
